ascon_fsm_ctrl: RTL and testbench
=================================

// Module: ascon_fsm_ctrl
// PURPOSE
// - Sequencing FSM for the ASCON-128 permutation_xor datapath (encryption only).
// - Drives round index, state-register enable, load/permute mux select and all XOR enables.
// - Phases: initialisation (pa), associated data (pb), plaintext (pb), finalisation (pa).
// - Accepts 64-bit AD/plaintext blocks through a valid/ready handshake; flags cipher and tag capture.
// PARAMETERS
// - AD_BLOCKS  1  number of 64-bit AD blocks (0 allowed)
// - PT_BLOCKS  4  number of 64-bit plaintext blocks (>=1)
// PORTS
// - clock_i              in   1  system clock, rising edge
// - reset_i              in   1  asynchronous reset, active-high
// - start_i              in   1  start one encryption; sampled in IDLE only
// - data_valid_i         in   1  AD/plaintext block available on datapath data_i
// - data_ready_o         out  1  FSM can take a block this cycle
// - round_o              out  4  round index to datapath
// - en_reg_state_o       out  1  state register enable
// - state_mode_o         out  1  0 = load IV||K||N, 1 = permutation output
// - en_xor_key_begin_o   out  1  XOR key into capacity at permutation input
// - en_xor_data_o        out  1  XOR data_i into word 0 at permutation input
// - en_xor_key_end_o     out  1  XOR key at permutation output
// - en_xor_lsb_o         out  1  XOR domain-separation bit at permutation output
// - en_cipher_o          out  1  cipher_o register capture
// - en_tag_o             out  1  tag_o register capture
// - busy_o               out  1  high in every state except IDLE
// - done_o               out  1  one-cycle pulse, tag valid
// BEHAVIOUR
// - Reset: state IDLE; every output 0; round counter 0; block counter 0. Reset mid-operation aborts at once; no residue.
// - Cycle n = n-th rising edge after start_i is sampled high in IDLE.
// - IDLE: outputs 0. start_i=1 -> LOAD.
// - LOAD (1 cycle): state_mode_o=0, en_reg_state_o=1, round_o=0 -> INIT.
// - INIT: state_mode_o=1, en_reg_state_o=1, round_o 0..11 (one per cycle). Round 11: en_xor_key_end_o=1.
//   If AD_BLOCKS=0, en_xor_lsb_o=1 in the same cycle. Round 11 -> WAIT_AD, or WAIT_PT if AD_BLOCKS=0.
// - WAIT_AD / WAIT_PT: data_ready_o=1, round_o=6 (WAIT_PT last block: round_o=0).
//   - en_reg_state_o = en_xor_data_o = data_valid_i. Accept cycle = valid & ready = first permutation round; no bubble.
//   - valid low: state held, no enables.
// - AD_RND: rounds 7..11. Round 11 of the last AD block: en_xor_lsb_o=1. Then WAIT_AD while blocks remain, else WAIT_PT.
// - WAIT_PT accept: en_cipher_o=1. Non-last block -> PT_RND; last block also asserts en_xor_key_begin_o -> FINAL.
// - PT_RND: rounds 7..11 -> WAIT_PT.
// - FINAL: rounds 1..11. Round 11: en_xor_key_end_o=1, en_tag_o=1 -> DONE.
// - DONE (1 cycle): done_o=1, busy_o=1 -> IDLE. start_i in DONE is ignored.
// - Counters: 4-bit round counter, no wrap past 11. Block counter width $clog2(max(AD,PT)+1); cleared on phase change.
// - start_i outside IDLE and data_valid_i outside WAIT_* are ignored.
// - Minimum latency with data always valid: 2+12+6*AD_BLOCKS+6*(PT_BLOCKS-1)+12 cycles to done_o.
//   Defaults: done_o at cycle 50.
// CONFIGURATION
// - ASCON_FSM_ABORT_EN defined:
//   - Adds input abort_i (1 bit). abort_i=1 in any non-IDLE state -> IDLE next edge, all outputs 0.
//   - No done_o, en_tag_o or en_cipher_o in the abort cycle.
// - Not defined: no abort_i port; only reset_i interrupts a run.
// TESTING
// - Defaults, start_i at cycle 0, data_valid_i held 1 -> LOAD c1; key_end c13; lsb c19;
//   en_cipher_o c20,26,32,38; key_begin c38; en_tag_o c49; done_o c50 only.
// - Key/nonce 8a55114d1cb6a9a2be263d4d7aecaaff, full run with datapath -> tag_o matches the ASCON-128 golden model.
// - data_valid_i low 3 cycles in WAIT_PT -> state frozen (en_reg_state_o=0, round_o=6); done_o slips to c53.
// - AD_BLOCKS=0 -> en_xor_key_end_o and en_xor_lsb_o both 1 at c13; first en_cipher_o at c14.
// - reset_i pulsed during INIT round 5 -> all outputs 0 same cycle; next start_i gives a normal run.
// - ASCON_FSM_ABORT_EN, abort_i at c25 -> busy_o=0 at c26; no en_tag_o/done_o; start_i in IDLE ignored while busy.

Source files
------------

// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl - sequencing FSM for the ASCON-128 permutation_xor datapath
// (encryption only).
//
// Phases: LOAD, INIT (pa, 12 rounds), per-AD-block pb, per-PT-block pb,
// FINAL (pa), then a one-cycle DONE pulse. The first pb round of every block
// runs in the same cycle the block is accepted (WAIT_* state). That round
// always uses round index 6, except for the last PT block, whose accept cycle
// is round 0 of the finalisation permutation.
//
// Parameters:
//   AD_BLOCKS  number of 64-bit associated-data blocks (0 allowed)
//   PT_BLOCKS  number of 64-bit plaintext blocks (>=1)
//
// Ports:
//   clock_i, reset_i (async, active-high)
//   start_i            start one encryption (sampled in IDLE only)
//   data_valid_i       block present on datapath data_i
//   data_ready_o       FSM can take a block this cycle
//   round_o            round index to datapath
//   en_reg_state_o     state register enable
//   state_mode_o       0 = load IV||K||N, 1 = permutation output
//   en_xor_key_begin_o, en_xor_data_o, en_xor_key_end_o, en_xor_lsb_o
//   en_cipher_o, en_tag_o, busy_o, done_o
//
// Optional macro ASCON_FSM_ABORT_EN: adds abort_i, which returns any
// non-IDLE state to IDLE on the next edge with no captures in that cycle.
module ascon_fsm_ctrl #(
  parameter int AD_BLOCKS = 1,
  parameter int PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
`ifdef ASCON_FSM_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       en_reg_state_o,
  output logic       state_mode_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int MAXB = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
  localparam int BW   = (MAXB < 1) ? 1 : $clog2(MAXB + 1);
  localparam logic [BW-1:0] AD_LAST = BW'(AD_BLOCKS);     // count after last AD accept
  localparam logic [BW-1:0] PT_LAST = BW'(PT_BLOCKS - 1); // index of last PT block

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_WAIT_AD, S_AD_RND, S_WAIT_PT, S_PT_RND, S_FINAL, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      rnd, rnd_nxt;
  logic [BW-1:0]   blk, blk_nxt;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      rnd   <= '0;
      blk   <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      blk   <= blk_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    rnd_nxt            = rnd;
    blk_nxt            = blk;
    data_ready_o       = 1'b0;
    round_o            = 4'd0;
    en_reg_state_o     = 1'b0;
    state_mode_o       = 1'b0;
    en_xor_key_begin_o = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_key_end_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_cipher_o        = 1'b0;
    en_tag_o           = 1'b0;
    busy_o             = 1'b1;
    done_o             = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o  = 1'b0;
        rnd_nxt = 4'd0;
        blk_nxt = '0;
        if (start_i) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        en_reg_state_o = 1'b1;
        rnd_nxt        = 4'd0;
        state_nxt      = S_INIT;
      end
      S_INIT: begin
        en_reg_state_o = 1'b1;
        state_mode_o   = 1'b1;
        round_o        = rnd;
        if (rnd == 4'd11) begin
          en_xor_key_end_o = 1'b1;
          // With no AD the domain-separation bit lands right after init.
          en_xor_lsb_o     = (AD_BLOCKS == 0);
          state_nxt        = (AD_BLOCKS == 0) ? S_WAIT_PT : S_WAIT_AD;
          rnd_nxt          = 4'd0;
          blk_nxt          = '0;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_WAIT_AD: begin
        data_ready_o   = 1'b1;
        state_mode_o   = 1'b1;
        round_o        = 4'd6;
        en_reg_state_o = data_valid_i;
        en_xor_data_o  = data_valid_i;
        if (data_valid_i) begin
          rnd_nxt   = 4'd7;
          blk_nxt   = blk + 1'b1;
          state_nxt = S_AD_RND;
        end
      end
      S_AD_RND: begin
        en_reg_state_o = 1'b1;
        state_mode_o   = 1'b1;
        round_o        = rnd;
        if (rnd == 4'd11) begin
          if (blk == AD_LAST) begin
            en_xor_lsb_o = 1'b1;
            blk_nxt      = '0;
            state_nxt    = S_WAIT_PT;
          end else begin
            state_nxt    = S_WAIT_AD;
          end
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_WAIT_PT: begin
        data_ready_o       = 1'b1;
        state_mode_o       = 1'b1;
        round_o            = (blk == PT_LAST) ? 4'd0 : 4'd6;
        en_reg_state_o     = data_valid_i;
        en_xor_data_o      = data_valid_i;
        en_cipher_o        = data_valid_i;
        en_xor_key_begin_o = data_valid_i && (blk == PT_LAST);
        if (data_valid_i) begin
          if (blk == PT_LAST) begin
            rnd_nxt   = 4'd1;
            state_nxt = S_FINAL;
          end else begin
            rnd_nxt   = 4'd7;
            blk_nxt   = blk + 1'b1;
            state_nxt = S_PT_RND;
          end
        end
      end
      S_PT_RND: begin
        en_reg_state_o = 1'b1;
        state_mode_o   = 1'b1;
        round_o        = rnd;
        if (rnd == 4'd11) state_nxt = S_WAIT_PT;
        else              rnd_nxt   = rnd + 4'd1;
      end
      S_FINAL: begin
        en_reg_state_o = 1'b1;
        state_mode_o   = 1'b1;
        round_o        = rnd;
        if (rnd == 4'd11) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          state_nxt        = S_DONE;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_o    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
`ifdef ASCON_FSM_ABORT_EN
    // Abort wins over everything: no captures or done in this cycle; busy
    // stays high until IDLE is reached on the next edge.
    if (abort_i && state != S_IDLE) begin
      state_nxt          = S_IDLE;
      rnd_nxt            = 4'd0;
      blk_nxt            = '0;
      data_ready_o       = 1'b0;
      round_o            = 4'd0;
      en_reg_state_o     = 1'b0;
      state_mode_o       = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_data_o      = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_xor_lsb_o       = 1'b0;
      en_cipher_o        = 1'b0;
      en_tag_o           = 1'b0;
      done_o             = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Bench for ascon_fsm_ctrl: two instances (defaults, and AD_BLOCKS=0 /
// PT_BLOCKS=2). Expected outputs come from a per-run script of output
// vectors built from the phase description; block-accept entries stall while
// data_valid_i is low. Latency to done_o is also checked against the closed
// formula plus the number of stall cycles.
module tb_ascon_fsm_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start_a, valid_a, start_b, valid_b;
  logic [14:0] vec_a, vec_b;

  // {ready, round[3:0], reg, mode, key_begin, xor_data, key_end, lsb, cipher, tag, busy, done}
  localparam logic [14:0] STALL_MASK = 15'h7D02;

  always #5 clk = ~clk;

  ascon_fsm_ctrl u_dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a), .data_valid_i(valid_a),
`ifdef ASCON_FSM_ABORT_EN
    .abort_i(1'b0),
`endif
    .data_ready_o(vec_a[14]), .round_o(vec_a[13:10]), .en_reg_state_o(vec_a[9]),
    .state_mode_o(vec_a[8]), .en_xor_key_begin_o(vec_a[7]), .en_xor_data_o(vec_a[6]),
    .en_xor_key_end_o(vec_a[5]), .en_xor_lsb_o(vec_a[4]), .en_cipher_o(vec_a[3]),
    .en_tag_o(vec_a[2]), .busy_o(vec_a[1]), .done_o(vec_a[0])
  );

  ascon_fsm_ctrl #(.AD_BLOCKS(0), .PT_BLOCKS(2)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b), .data_valid_i(valid_b),
`ifdef ASCON_FSM_ABORT_EN
    .abort_i(1'b0),
`endif
    .data_ready_o(vec_b[14]), .round_o(vec_b[13:10]), .en_reg_state_o(vec_b[9]),
    .state_mode_o(vec_b[8]), .en_xor_key_begin_o(vec_b[7]), .en_xor_data_o(vec_b[6]),
    .en_xor_key_end_o(vec_b[5]), .en_xor_lsb_o(vec_b[4]), .en_cipher_o(vec_b[3]),
    .en_tag_o(vec_b[2]), .busy_o(vec_b[1]), .done_o(vec_b[0])
  );

  typedef struct { logic [14:0] v; bit w; } ent_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(bit rdy, int rnd, bit rg, bit md, bit kb, bit xd,
                                     bit ke, bit lsb, bit ci, bit tg, bit bz, bit dn);
    logic [3:0] r4;
    r4 = 4'(rnd);
    return {rdy, r4, rg, md, kb, xd, ke, lsb, ci, tg, bz, dn};
  endfunction

  function automatic logic [14:0] get_vec(input int sel);
    return (sel == 0) ? vec_a : vec_b;
  endfunction

  task automatic set_in(input int sel, input logic s, input logic v);
    if (sel == 0) begin start_a = s; valid_a = v; end
    else          begin start_b = s; valid_b = v; end
  endtask

  // One encryption on DUT sel. stall_pct: chance of data_valid_i low per cycle.
  // rst_at > 0 pulses reset during that cycle and ends the run there.
  task automatic run(input int sel, input int ad, input int pt, input int stall_pct,
                     input int rst_at, input string nm);
    ent_t q[$];
    ent_t e;
    logic [14:0] exp, got;
    int cyc, n_stall, done_cyc;
    bit vld, s;
    // Script from the phase description.
    q.push_back('{mk(0,0,1,0,0,0,0,0,0,0,1,0), 1'b0});
    for (int r = 0; r <= 11; r++)
      q.push_back('{mk(0,r,1,1,0,0,r==11,(r==11)&&(ad==0),0,0,1,0), 1'b0});
    for (int b = 0; b < ad; b++) begin
      q.push_back('{mk(1,6,1,1,0,1,0,0,0,0,1,0), 1'b1});
      for (int r = 7; r <= 11; r++)
        q.push_back('{mk(0,r,1,1,0,0,0,(r==11)&&(b==ad-1),0,0,1,0), 1'b0});
    end
    for (int p = 0; p < pt; p++) begin
      bit last;
      last = (p == pt - 1);
      q.push_back('{mk(1,last?0:6,1,1,last,1,0,0,1,0,1,0), 1'b1});
      if (!last) for (int r = 7; r <= 11; r++)
        q.push_back('{mk(0,r,1,1,0,0,0,0,0,0,1,0), 1'b0});
      else for (int r = 1; r <= 11; r++)
        q.push_back('{mk(0,r,1,1,0,0,r==11,0,0,r==11,1,0), 1'b0});
    end
    q.push_back('{mk(0,0,0,0,0,0,0,0,0,0,1,1), 1'b0});

    @(posedge clk); #1;
    set_in(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    cyc = 1; n_stall = 0; done_cyc = 0;
    while (q.size() > 0) begin
      vld = ($urandom_range(99) >= stall_pct);
      s   = 1'($urandom_range(1));  // start_i outside IDLE must be ignored
      set_in(sel, s, vld);
      if (cyc == rst_at) begin
        rst = 1'b1; #1;
        check({nm, "_async_rst"}, get_vec(sel), 15'h0);
        @(posedge clk); #1;
        set_in(sel, 1'b0, 1'b0);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      e   = q[0];
      got = get_vec(sel);
      if (e.w && !vld) begin
        exp = e.v & STALL_MASK;
        n_stall++;
      end else begin
        exp = e.v;
        void'(q.pop_front());
      end
      if (got[0]) done_cyc = cyc;
      check($sformatf("%s_c%0d", nm, cyc), got, exp);
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin
        check({nm, "_timeout"}, 15'h1, 15'h0);
        break;
      end
    end
    set_in(sel, 1'b0, 1'b0);
    @(negedge clk);
    check({nm, "_idle_after"}, get_vec(sel), 15'h0);
    check({nm, "_done_cycle"}, 15'(done_cyc),
          15'(2 + 12 + 6*ad + 6*(pt-1) + 12 + n_stall));
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; valid_a = 0; start_b = 0; valid_b = 0;
    #1;
    check("reset_a", vec_a, 15'h0);
    check("reset_b", vec_b, 15'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(0, 1, 4, 0,  0, "a_full");     // done at c50
    run(0, 1, 4, 35, 0, "a_stall");
    run(0, 1, 4, 0,  7, "a_rst");      // reset during INIT round 5
    run(0, 1, 4, 0,  0, "a_after_rst");
    run(1, 0, 2, 0,  0, "b_full");
    run(1, 0, 2, 40, 0, "b_stall");
    for (int i = 0; i < 3; i++) run(0, 1, 4, 50, 0, "a_rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
